mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a five-stage pipeline. It holds one instruction in the MEM
// register, issues at most one data-memory request for it, and stalls the
// front of the pipeline until the memory answers. The result goes into the
// WB register, together with a flag for misaligned accesses.
//
// Ports
//   clock, reset          single rising-edge clock, asynchronous active-high reset
//   exValid .. isMemoryWrite
//                         instruction presented by the EX stage
//   memRequest/memWrite/memAddress/memWriteData
//                         data-memory request, driven from the MEM register only
//   memReady/memReadData  memory completion handshake and load data
//   shouldStall           freezes PC/IF/ID/EX while an access is outstanding
//   wb*                   WB register contents
//   stallCycleCount       saturating count of stalled cycles
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int STALL_COUNTER_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           exValid,
    input  logic [31:0]                    aluOutput,
    input  logic [31:0]                    registerRt,
    input  logic [4:0]                     registerWriteAddress,
    input  logic                           shouldWriteRegister,
    input  logic                           isMemoryRead,
    input  logic                           isMemoryWrite,
    output logic                           memRequest,
    output logic                           memWrite,
    output logic [31:0]                    memAddress,
    output logic [31:0]                    memWriteData,
    input  logic                           memReady,
    input  logic [31:0]                    memReadData,
    output logic                           shouldStall,
    output logic                           wbValid,
    output logic [4:0]                     wbRegisterWriteAddress,
    output logic                           wbRegisterWriteEnable,
    output logic [31:0]                    wbData,
    output logic                           wbAddressError,
    output logic [STALL_COUNTER_WIDTH-1:0] stallCycleCount
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } accessState_t;

    accessState_t state_q, state_d;

    // MEM register
    logic        memValid_q;
    logic [31:0] memAddress_q;
    logic [31:0] memStoreData_q;
    logic [4:0]  memDest_q;
    logic        memWriteReg_q;
    logic        memRead_q;
    logic        memStore_q;

    // WB register
    logic        wbValid_q,       wbValid_d;
    logic [4:0]  wbRegAddress_q,  wbRegAddress_d;
    logic        wbWriteEnable_q, wbWriteEnable_d;
    logic [31:0] wbData_q,        wbData_d;
    logic        wbAddressError_q, wbAddressError_d;

    logic [STALL_COUNTER_WIDTH-1:0] stallCount_q, stallCount_d;

    logic isMemOp;
    logic misaligned;
    logic isLoad;

    // A store wins over a load if both control bits are ever set together.
    assign isMemOp     = memValid_q & (memRead_q | memStore_q);
    assign misaligned  = isMemOp & (memAddress_q[1:0] != 2'b00);
    assign isLoad      = memRead_q & ~memStore_q;

    // The request depends only on MEM-register state, so the address and data
    // stay stable for as long as the MEM register is frozen by the stall.
    assign memRequest   = isMemOp & ~misaligned;
    assign memWrite     = memStore_q;
    assign memAddress   = memAddress_q;
    assign memWriteData = memStoreData_q;
    assign shouldStall  = memRequest & ~memReady;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (memRequest && !memReady) state_d = ST_WAIT;
            ST_WAIT: if (memReady)                state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The MEM register freezes while the access is outstanding; a bubble from
    // EX is captured like any instruction, its cleared valid bit suppresses
    // both the request and the register write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memValid_q     <= 1'b0;
            memAddress_q   <= '0;
            memStoreData_q <= '0;
            memDest_q      <= '0;
            memWriteReg_q  <= 1'b0;
            memRead_q      <= 1'b0;
            memStore_q     <= 1'b0;
        end else if (!shouldStall) begin
            memValid_q     <= exValid;
            memAddress_q   <= aluOutput;
            memStoreData_q <= registerRt;
            memDest_q      <= registerWriteAddress;
            memWriteReg_q  <= shouldWriteRegister;
            memRead_q      <= isMemoryRead;
            memStore_q     <= isMemoryWrite;
        end
    end

    // While stalled the WB register takes a bubble but keeps its data and
    // destination, so a consumer never sees a spurious value change.
    // Read data is only taken when a load actually reached memory; a
    // misaligned load forwards the address instead.
    always_comb begin
        wbValid_d        = 1'b0;
        wbRegAddress_d   = wbRegAddress_q;
        wbWriteEnable_d  = 1'b0;
        wbData_d         = wbData_q;
        wbAddressError_d = 1'b0;
        if (!shouldStall) begin
            wbValid_d        = memValid_q;
            wbRegAddress_d   = memDest_q;
            wbWriteEnable_d  = memValid_q & memWriteReg_q & ~misaligned & ~memStore_q;
            wbData_d         = (memRequest && isLoad) ? memReadData : memAddress_q;
            wbAddressError_d = misaligned;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbValid_q        <= 1'b0;
            wbRegAddress_q   <= '0;
            wbWriteEnable_q  <= 1'b0;
            wbData_q         <= '0;
            wbAddressError_q <= 1'b0;
        end else begin
            wbValid_q        <= wbValid_d;
            wbRegAddress_q   <= wbRegAddress_d;
            wbWriteEnable_q  <= wbWriteEnable_d;
            wbData_q         <= wbData_d;
            wbAddressError_q <= wbAddressError_d;
        end
    end

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        stallCount_d = stallCount_q;
        if (shouldStall && (stallCount_q != '1)) begin
            stallCount_d = stallCount_q + STALL_COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign wbValid                = wbValid_q;
    assign wbRegisterWriteAddress = wbRegAddress_q;
    assign wbRegisterWriteEnable  = wbWriteEnable_q;
    assign wbData                 = wbData_q;
    assign wbAddressError         = wbAddressError_q;
    assign stallCycleCount        = stallCount_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed scenarios followed by random traffic for mem_stage. A second copy
// with a 4-bit stall counter runs on the same inputs to show saturation.
// Expected values come from an instruction-level model of the stage.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        exValid;
    logic [31:0] aluOutput;
    logic [31:0] registerRt;
    logic [4:0]  registerWriteAddress;
    logic        shouldWriteRegister;
    logic        isMemoryRead;
    logic        isMemoryWrite;
    logic        memReady;
    logic [31:0] memReadData;

    logic        memRequest, memWrite, shouldStall;
    logic [31:0] memAddress, memWriteData, wbData;
    logic        wbValid, wbRegisterWriteEnable, wbAddressError;
    logic [4:0]  wbRegisterWriteAddress;
    logic [31:0] stallCycleCount;

    logic        memRequestS, memWriteS, shouldStallS;
    logic [31:0] memAddressS, memWriteDataS, wbDataS;
    logic        wbValidS, wbRegisterWriteEnableS, wbAddressErrorS;
    logic [4:0]  wbRegisterWriteAddressS;
    logic [3:0]  stallCycleCountS;

    int checkCount = 0;
    int passCount  = 0;

    // Instruction-level model: the instruction sitting in MEM and the WB view.
    logic        mValid, mWreg, mRd, mSt;
    logic [31:0] mAddr, mData;
    logic [4:0]  mDest;
    logic        eWbValid, eWbWe, eWbErr;
    logic [4:0]  eWbAddr;
    logic [31:0] eWbData;
    longint      eCnt;
    int          eCntSat;

    mem_stage dut (
        .clock(clock), .reset(reset), .exValid(exValid), .aluOutput(aluOutput),
        .registerRt(registerRt), .registerWriteAddress(registerWriteAddress),
        .shouldWriteRegister(shouldWriteRegister), .isMemoryRead(isMemoryRead),
        .isMemoryWrite(isMemoryWrite), .memRequest(memRequest), .memWrite(memWrite),
        .memAddress(memAddress), .memWriteData(memWriteData), .memReady(memReady),
        .memReadData(memReadData), .shouldStall(shouldStall), .wbValid(wbValid),
        .wbRegisterWriteAddress(wbRegisterWriteAddress),
        .wbRegisterWriteEnable(wbRegisterWriteEnable), .wbData(wbData),
        .wbAddressError(wbAddressError), .stallCycleCount(stallCycleCount)
    );

    mem_stage #(.STALL_COUNTER_WIDTH(4)) dutSat (
        .clock(clock), .reset(reset), .exValid(exValid), .aluOutput(aluOutput),
        .registerRt(registerRt), .registerWriteAddress(registerWriteAddress),
        .shouldWriteRegister(shouldWriteRegister), .isMemoryRead(isMemoryRead),
        .isMemoryWrite(isMemoryWrite), .memRequest(memRequestS), .memWrite(memWriteS),
        .memAddress(memAddressS), .memWriteData(memWriteDataS), .memReady(memReady),
        .memReadData(memReadData), .shouldStall(shouldStallS), .wbValid(wbValidS),
        .wbRegisterWriteAddress(wbRegisterWriteAddressS),
        .wbRegisterWriteEnable(wbRegisterWriteEnableS), .wbData(wbDataS),
        .wbAddressError(wbAddressErrorS), .stallCycleCount(stallCycleCountS)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic modelMisaligned();
        return mValid && (mRd || mSt) && ((mAddr % 4) != 0);
    endfunction

    function automatic logic modelRequest();
        return mValid && (mRd || mSt) && !modelMisaligned();
    endfunction

    task automatic modelReset();
        mValid = 0; mWreg = 0; mRd = 0; mSt = 0;
        mAddr = 0; mData = 0; mDest = 0;
        eWbValid = 0; eWbWe = 0; eWbErr = 0; eWbAddr = 0; eWbData = 0;
        eCnt = 0; eCntSat = 0;
    endtask

    // Applies the rules of one rising edge using the inputs present at it.
    task automatic modelEdge();
        logic mis, req, stall;
        mis   = modelMisaligned();
        req   = modelRequest();
        stall = req && !memReady;
        if (stall) begin
            eWbValid = 0;
            eWbWe    = 0;
            eWbErr   = 0;
            if (eCnt < 64'hFFFF_FFFF) eCnt++;
            if (eCntSat < 15) eCntSat++;
        end else begin
            eWbValid = mValid;
            eWbAddr  = mDest;
            eWbWe    = mValid && mWreg && !mis && !mSt;
            eWbData  = (req && mRd && !mSt) ? memReadData : mAddr;
            eWbErr   = mis;
            mValid = exValid; mAddr = aluOutput; mData = registerRt;
            mDest = registerWriteAddress; mWreg = shouldWriteRegister;
            mRd = isMemoryRead; mSt = isMemoryWrite;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] alu,
                                 input logic [31:0] rt, input logic [4:0] dest,
                                 input logic wreg, input logic rd, input logic st,
                                 input logic ready, input logic [31:0] rdata);
        exValid = v; aluOutput = alu; registerRt = rt; registerWriteAddress = dest;
        shouldWriteRegister = wreg; isMemoryRead = rd; isMemoryWrite = st;
        memReady = ready; memReadData = rdata;
    endtask

    // Starts just after a rising edge; checks the request side mid-cycle,
    // then the WB side just after the next edge.
    task automatic stepCycle(input string tag);
        #1;
        checkOutput({tag, ".memRequest"}, memRequest, modelRequest());
        checkOutput({tag, ".shouldStall"}, shouldStall, modelRequest() && !memReady);
        if (modelRequest()) begin
            checkOutput({tag, ".memAddress"}, memAddress, mAddr);
            checkOutput({tag, ".memWrite"}, memWrite, mSt);
            checkOutput({tag, ".memWriteData"}, memWriteData, mData);
        end
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput({tag, ".wbValid"}, wbValid, eWbValid);
        checkOutput({tag, ".wbAddr"}, wbRegisterWriteAddress, eWbAddr);
        checkOutput({tag, ".wbWe"}, wbRegisterWriteEnable, eWbWe);
        checkOutput({tag, ".wbData"}, wbData, eWbData);
        checkOutput({tag, ".wbErr"}, wbAddressError, eWbErr);
        checkOutput({tag, ".stallCount"}, stallCycleCount, eCnt[31:0]);
        checkOutput({tag, ".stallCountSat"}, stallCycleCountS, eCntSat);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".memRequest"}, memRequest, 0);
        checkOutput({tag, ".shouldStall"}, shouldStall, 0);
        checkOutput({tag, ".memWrite"}, memWrite, 0);
        checkOutput({tag, ".memAddress"}, memAddress, 0);
        checkOutput({tag, ".memWriteData"}, memWriteData, 0);
        checkOutput({tag, ".wbValid"}, wbValid, 0);
        checkOutput({tag, ".wbAddr"}, wbRegisterWriteAddress, 0);
        checkOutput({tag, ".wbWe"}, wbRegisterWriteEnable, 0);
        checkOutput({tag, ".wbData"}, wbData, 0);
        checkOutput({tag, ".wbErr"}, wbAddressError, 0);
        checkOutput({tag, ".stallCount"}, stallCycleCount, 0);
        checkOutput({tag, ".stallCountSat"}, stallCycleCountS, 0);
    endtask

    // Asserts reset between edges and checks everything cleared before the next edge.
    task automatic resetPulse(input string tag);
        reset = 1'b1;
        #2;
        modelReset();
        checkResetState(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int reqCount;
        int kind;
        logic [31:0] addr;

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        @(posedge clock);
        #1;
        checkResetState("initReset");
        reset = 1'b0;

        // Zero-wait load
        applyStimulus(1, 32'h100, 0, 5, 1, 1, 0, 1, 0);
        stepCycle("zwIssue");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        #1;
        checkOutput("zwRequest", memRequest, 1);
        checkOutput("zwNoStall", shouldStall, 0);
        stepCycle("zwDone");
        checkOutput("zwData", wbData, 32'hDEAD_BEEF);
        checkOutput("zwDest", wbRegisterWriteAddress, 5);
        checkOutput("zwWe", wbRegisterWriteEnable, 1);

        // Wait-state store, counter starting from zero
        resetPulse("midReset");
        applyStimulus(1, 32'h200, 32'h1234_5678, 9, 1, 0, 1, 1, 0);
        stepCycle("stIssue");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            stepCycle("stWait");
            checkOutput("stBubble", wbValid, 0);
            checkOutput("stAddrStable", memAddress, 32'h200);
            checkOutput("stDataStable", memWriteData, 32'h1234_5678);
        end
        memReady = 1'b1;
        stepCycle("stDone");
        checkOutput("stStallCount", stallCycleCount, 3);
        checkOutput("stWbValid", wbValid, 1);
        checkOutput("stNoWe", wbRegisterWriteEnable, 0);

        // Misaligned load with memReady low to show it is ignored
        applyStimulus(1, 32'h103, 0, 6, 1, 1, 0, 0, 32'h5555_5555);
        stepCycle("maIssue");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("maNoRequest", memRequest, 0);
        checkOutput("maNoStall", shouldStall, 0);
        stepCycle("maDone");
        checkOutput("maErr", wbAddressError, 1);
        checkOutput("maNoWe", wbRegisterWriteEnable, 0);
        checkOutput("maValid", wbValid, 1);

        // Back-to-back ALU op, load, store
        reqCount = 0;
        applyStimulus(1, 32'h7, 0, 3, 1, 0, 0, 1, 0);
        stepCycle("b2bAlu");
        reqCount += int'(memRequest);
        applyStimulus(1, 32'h40, 0, 4, 1, 1, 0, 1, 0);
        stepCycle("b2bLoad");
        reqCount += int'(memRequest);
        checkOutput("b2bAluData", wbData, 7);
        checkOutput("b2bAluWe", wbRegisterWriteEnable, 1);
        applyStimulus(1, 32'h44, 32'hA5A5_0001, 8, 0, 0, 1, 1, 32'hCAFE_F00D);
        stepCycle("b2bStore");
        reqCount += int'(memRequest);
        checkOutput("b2bLoadValid", wbValid, 1);
        checkOutput("b2bLoadData", wbData, 32'hCAFE_F00D);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        stepCycle("b2bTail1");
        reqCount += int'(memRequest);
        checkOutput("b2bStoreValid", wbValid, 1);
        checkOutput("b2bStoreNoWe", wbRegisterWriteEnable, 0);
        stepCycle("b2bTail2");
        reqCount += int'(memRequest);
        checkOutput("b2bRequestCycles", reqCount, 2);

        // Reset during an outstanding access; a late memReady changes nothing
        applyStimulus(1, 32'h300, 0, 7, 1, 1, 0, 0, 0);
        stepCycle("rwIssue");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("rwWait");
        resetPulse("rwReset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
        stepCycle("rwLateReady");
        checkOutput("rwNoWb", wbValid, 0);
        checkOutput("rwNoData", wbData, 0);

        // Saturation of the narrow counter
        resetPulse("satReset");
        applyStimulus(1, 32'h10, 32'h1, 2, 0, 0, 1, 0, 0);
        stepCycle("satIssue");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) stepCycle("satWait");
        checkOutput("satHeld", stallCycleCountS, 15);
        checkOutput("satWide", stallCycleCount, 20);
        memReady = 1'b1;
        stepCycle("satDone");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom;
            if (kind != 0 && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 3) != 0, addr, $urandom,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          kind == 1, kind == 2, 1'($urandom_range(0, 1)), $urandom);
            stepCycle("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
